// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants for the BCD countdown timer: state encodings and BCD digit helpers.
package bcd_countdown_timer_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_RUN    = 2'd1;
    localparam logic [1:0]  ST_PAUSED = 2'd2;
    localparam logic [1:0]  ST_DONE   = 2'd3;

    // Out-of-range nibbles saturate to 9 so the count is always valid BCD.
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer.
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  zero;
    logic                  done;

    modport master (
        output load, load_val, start, pause,
        input  count, running, zero, done
    );

    modport slave (
        input  load, load_val, start, pause,
        output count, running, zero, done
    );
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the down-counter: decrements when borrowed from, wraps 0 -> 9 with borrow out.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_borrow,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_borrow
);

    always_comb begin
        o_digit  = i_digit;
        o_borrow = 1'b0;
        if (i_borrow) begin
            if (i_digit == 4'd0) begin
                o_digit  = BCD_MAX;
                o_borrow = 1'b1;
            end else begin
                o_digit  = i_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable DIGITS-wide BCD down-counter, one decrement per PRESCALE clocks while running,
// with pause/resume, a one-cycle done pulse and a level zero flag.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,   // asynchronous, active low
    bcd_countdown_timer_if.slave      bus
);

    localparam int               W       = BCD_W * DIGITS;
    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [1:0]                        r_state;
    logic [PS_W-1:0]                   r_ps;
    logic [W-1:0]                      r_count;
    logic                              r_running;
    logic                              r_done;

    logic [DIGITS-1:0][BCD_W-1:0]      w_cur;
    logic [DIGITS-1:0][BCD_W-1:0]      w_dec;
    logic [DIGITS:0]                   w_borrow;
    logic [W-1:0]                      w_next;
    logic [W-1:0]                      w_load;
    logic                              w_tick;

    assign w_cur       = r_count;
    assign w_borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_down u_digit (
                .i_digit  (w_cur[g]),
                .i_borrow (w_borrow[g]),
                .o_digit  (w_dec[g]),
                .o_borrow (w_borrow[g+1])
            );
        end
    endgenerate

    // A borrow out of the top digit would mean decrementing from zero; pin the count at 0 instead.
    assign w_next = w_borrow[DIGITS] ? '0 : W'(w_dec);

    always_comb begin
        w_load = '0;
        for (int d = 0; d < DIGITS; d++)
            w_load[d*BCD_W +: BCD_W] = clamp_bcd(bus.load_val[d*BCD_W +: BCD_W]);
    end

    assign w_tick = (r_ps == PS_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_ps      <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.load) begin
                r_state   <= ST_IDLE;
                r_ps      <= '0;
                r_count   <= w_load;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start && !bus.pause) begin
                            r_ps <= '0;
                            if (r_count != '0) begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.pause) begin
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_ps    <= '0;
                            r_count <= w_next;
                            if (w_next == '0) begin
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_ps <= r_ps + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        // Prescaler is left untouched so the interrupted tick period resumes.
                        if (bus.start && !bus.pause) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.zero    = (r_count == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs, a monitor pops and compares.
module tb_bcd_countdown_timer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_countdown_timer_if #(.DIGITS(2)) u0_if ();
    bcd_countdown_timer_if #(.DIGITS(2)) u1_if ();

    bcd_countdown_timer #(.DIGITS(2), .PRESCALE(4)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (u0_if.slave)
    );

    bcd_countdown_timer #(.DIGITS(2), .PRESCALE(1)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (u1_if.slave)
    );

    typedef struct {
        bit         sel;
        logic [7:0] cnt;
        bit         run;
        bit         done;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // One cycle on the PRESCALE=4 instance: drive, queue the expectation after the next edge.
    task automatic tick(input bit ld, input logic [7:0] lv, input bit st, input bit ps,
                        input logic [7:0] ecnt, input bit erun, input bit edone, input string tag);
        exp_t e;
        u0_if.load = ld; u0_if.load_val = lv; u0_if.start = st; u0_if.pause = ps;
        e.sel = 1'b0; e.cnt = ecnt; e.run = erun; e.done = edone; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick1(input bit ld, input logic [7:0] lv, input bit st,
                         input logic [7:0] ecnt, input bit erun, input bit edone, input string tag);
        exp_t e;
        u1_if.load = ld; u1_if.load_val = lv; u1_if.start = st; u1_if.pause = 1'b0;
        e.sel = 1'b1; e.cnt = ecnt; e.run = erun; e.done = edone; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            if (!m_e.sel) begin
                chk({m_e.tag, ".count"},   32'(u0_if.count),   32'(m_e.cnt));
                chk({m_e.tag, ".running"}, 32'(u0_if.running), 32'(m_e.run));
                chk({m_e.tag, ".done"},    32'(u0_if.done),    32'(m_e.done));
                chk({m_e.tag, ".zero"},    32'(u0_if.zero),    32'(m_e.cnt == 8'h00));
            end else begin
                chk({m_e.tag, ".count"},   32'(u1_if.count),   32'(m_e.cnt));
                chk({m_e.tag, ".running"}, 32'(u1_if.running), 32'(m_e.run));
                chk({m_e.tag, ".done"},    32'(u1_if.done),    32'(m_e.done));
                chk({m_e.tag, ".zero"},    32'(u1_if.zero),    32'(m_e.cnt == 8'h00));
            end
        end
    end

    initial begin
        int c, act;
        rst_n = 1'b0;
        u0_if.load = 0; u0_if.load_val = '0; u0_if.start = 0; u0_if.pause = 0;
        u1_if.load = 0; u1_if.load_val = '0; u1_if.start = 0; u1_if.pause = 0;
        #1;
        chk("rst.count",   32'(u0_if.count),   32'h0);
        chk("rst.running", 32'(u0_if.running), 32'h0);
        chk("rst.done",    32'(u0_if.done),    32'h0);
        chk("rst.zero",    32'(u0_if.zero),    32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // 12 down to 00: one decrement every 4 clocks, done on the 48th edge after start
        tick(1, 8'h12, 0, 0, 8'h12, 0, 0, "s1.load");
        tick(0, 8'h00, 1, 0, 8'h12, 1, 0, "s1.start");
        for (int k = 1; k <= 48; k++) begin
            c = 12 - k / 4;
            tick(0, 8'h00, 0, 0, bcd(c), c != 0, c == 0, $sformatf("s1.k%0d", k));
        end
        tick(0, 8'h00, 0, 0, 8'h00, 0, 0, "s1.after");
        tick(0, 8'h00, 1, 1, 8'h00, 0, 0, "s1.done_hold");

        // 03 with a 10-clock pause starting on the 6th edge after start
        tick(1, 8'h03, 0, 0, 8'h03, 0, 0, "s2.load");
        tick(0, 8'h00, 1, 0, 8'h03, 1, 0, "s2.start");
        for (int k = 1; k <= 22; k++) begin
            act = (k < 6) ? k : (k <= 15) ? 5 : k - 10;
            c = 3 - act / 4;
            tick(0, 8'h00, k == 15, k == 6, bcd(c), !(k >= 6 && k <= 14) && c != 0, c == 0,
                 $sformatf("s2.k%0d", k));
        end
        tick(0, 8'h00, 0, 0, 8'h00, 0, 0, "s2.after");

        // start from zero goes straight to DONE
        tick(1, 8'h00, 0, 0, 8'h00, 0, 0, "s3.load");
        tick(0, 8'h00, 1, 0, 8'h00, 0, 1, "s3.start");
        tick(0, 8'h00, 1, 0, 8'h00, 0, 0, "s3.after");

        // both nibbles clamp to 9
        tick(1, 8'hAF, 0, 0, 8'h99, 0, 0, "s4.load");
        tick(0, 8'h00, 1, 0, 8'h99, 1, 0, "s4.start");
        for (int k = 1; k <= 4; k++)
            tick(0, 8'h00, 0, 0, (k == 4) ? 8'h98 : 8'h99, 1, 0, $sformatf("s4.k%0d", k));

        // load wins over start+pause while running
        tick(1, 8'h05, 0, 0, 8'h05, 0, 0, "s5.load");
        tick(0, 8'h00, 1, 0, 8'h05, 1, 0, "s5.start");
        tick(0, 8'h00, 0, 0, 8'h05, 1, 0, "s5.run");
        tick(1, 8'h20, 1, 1, 8'h20, 0, 0, "s5.reload");
        tick(0, 8'h00, 0, 0, 8'h20, 0, 0, "s5.idle");

        // asynchronous reset mid-run
        tick(1, 8'h07, 0, 0, 8'h07, 0, 0, "s6.load");
        tick(0, 8'h00, 1, 0, 8'h07, 1, 0, "s6.start");
        tick(0, 8'h00, 0, 0, 8'h07, 1, 0, "s6.run");
        #2 rst_n = 1'b0;
        #1;
        chk("s6.arst.count",   32'(u0_if.count),   32'h0);
        chk("s6.arst.running", 32'(u0_if.running), 32'h0);
        chk("s6.arst.done",    32'(u0_if.done),    32'h0);
        chk("s6.arst.zero",    32'(u0_if.zero),    32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            tick(0, 8'h00, 0, 0, 8'h00, 0, 0, $sformatf("s6.post%0d", k));

        // PRESCALE=1 instance decrements every clock
        tick1(1, 8'h02, 0, 8'h02, 0, 0, "p1.load");
        tick1(0, 8'h00, 1, 8'h02, 1, 0, "p1.start");
        tick1(0, 8'h00, 0, 8'h01, 1, 0, "p1.t1");
        tick1(0, 8'h00, 0, 8'h00, 0, 1, "p1.t2");
        tick1(0, 8'h00, 0, 8'h00, 0, 0, "p1.after");

        @(negedge clk);
        chk("sb.drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
